// File: rtl/logic_unit_sliced.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/NOR over WIDTH bits, SLICE bits per clock,
// with valid/ready handshakes on both sides and n_z_v_c flags.
module logic_unit_sliced #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags_n_z_v_c
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       op_r;
  logic [IDXW-1:0]  idx_r;
  logic             ones_r;
  logic [WIDTH-1:0] out_r;
  logic [3:0]       flags_r;
  logic [WIDTH-1:0] a_sh_s;
  logic [WIDTH-1:0] b_sh_s;
  logic [SLICE-1:0] res_s;

  function automatic logic [SLICE-1:0] apply_op(
    input logic [1:0]       sel,
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b
  );
    logic [SLICE-1:0] r;
    case (sel)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~(a | b);
      default: r = {SLICE{1'b0}};
    endcase
    return r;
  endfunction

  // The active slice is brought down to bit 0 so one narrow operator serves every slice.
  assign a_sh_s = a_r >> (idx_r * SLICE);
  assign b_sh_s = b_r >> (idx_r * SLICE);
  assign res_s  = apply_op(op_r, a_sh_s[SLICE-1:0], b_sh_s[SLICE-1:0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (idx_r == LAST_IDX) state_nxt_s = ST_DONE;
        else                   state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand latch, slice sweep and flag capture; DONE holds everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      op_r    <= 2'b00;
      idx_r   <= {IDXW{1'b0}};
      ones_r  <= 1'b0;
      out_r   <= {WIDTH{1'b0}};
      flags_r <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r    <= in_a;
            b_r    <= in_b;
            op_r   <= op;
            idx_r  <= {IDXW{1'b0}};
            ones_r <= 1'b0;
            out_r  <= {WIDTH{1'b0}};
          end
        end
        ST_RUN: begin
          // out was cleared on acceptance, so OR-ing the shifted slice writes it in place.
          out_r  <= out_r | (WIDTH'(res_s) << (idx_r * SLICE));
          ones_r <= ones_r | (|res_s);
          if (idx_r == LAST_IDX) begin
            flags_r <= {res_s[SLICE-1], ~(ones_r | (|res_s)), 2'b00};
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out           = out_r;
  assign flags_n_z_v_c = flags_r;

endmodule

// File: tb/tb_logic_unit_sliced.sv
// Directed, scoreboard-based bench for logic_unit_sliced: 16/4 main instance plus
// 16/16 and 8/1 parameter corners.
module tb_logic_unit_sliced;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op;
  logic [15:0] in_a, in_b, out;
  logic [3:0]  flags;

  logic        iv16, ir16, ov16, or16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, o16;
  logic [3:0]  f16;

  logic        iv8, ir8, ov8, or8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, o8;
  logic [3:0]  f8;

  logic_unit_sliced #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags_n_z_v_c(flags));

  logic_unit_sliced #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16),
    .in_a(a16), .in_b(b16), .out_valid(ov16), .out_ready(or16),
    .out(o16), .flags_n_z_v_c(f16));

  logic_unit_sliced #(.WIDTH(8), .SLICE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8),
    .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(or8),
    .out(o8), .flags_n_z_v_c(f8));

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   compared = 0;
  int   mismatched = 0;

  function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                                 input int w);
    exp_t        e;
    logic [15:0] r;
    logic [15:0] mask;
    case (o)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a | b);
    endcase
    mask  = (w == 16) ? 16'hFFFF : ((16'h0001 << w) - 16'h0001);
    r     = r & mask;
    e.res = r;
    e.fl  = {r[w-1], (r == 16'h0000), 2'b00};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_exp(input string tag, output exp_t e);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic accept(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    op = o; in_a = a; in_b = b; in_valid = 1'b1;
    sb.push_back(model(o, a, b, 16));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input bit toggle);
    int   cyc = 0;
    bit   ir_seen = 1'b0;
    exp_t e;
    while (!out_valid && cyc < 50) begin
      if (toggle) begin
        in_a = ~in_a; in_b = in_b + 16'h0003; op = op + 2'd1;
      end
      @(negedge clk);
      cyc++;
      if (in_ready) ir_seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd4);
    check({tag, "_in_ready_low"}, 32'(ir_seen), 32'd0);
    pop_exp(tag, e);
    last_e = e;
    check({tag, "_out"}, 32'(out), 32'(e.res));
    check({tag, "_flags"}, 32'(flags), 32'(e.fl));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_k, naccept, nres, cyc;
    exp_t e;
    rst_n = 1'b1; in_valid = 1'b0; op = 2'b00; in_a = 16'h0; in_b = 16'h0; out_ready = 1'b0;
    iv16 = 1'b0; op16 = 2'b00; a16 = 16'h0; b16 = 16'h0; or16 = 1'b0;
    iv8 = 1'b0; op8 = 2'b00; a8 = 8'h0; b8 = 8'h0; or8 = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    check("reset_state", {9'd0, in_ready, out_valid, flags, out},
          {9'd0, 1'b1, 1'b0, 4'b0000, 16'h0000});
    check("reset_corners", {28'd0, ir16, ov16, ir8, ov8}, {28'd0, 4'b1010});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Main function and flag patterns
    accept(2'b10, 16'hA5A5, 16'h0FF0); wait_result("xor", 1'b0); release_result("xor");
    check("xor_value", 32'(last_e.res), 32'h0000AA55);
    accept(2'b10, 16'h1234, 16'h1234); wait_result("xor_zero", 1'b0); release_result("xor_zero");
    accept(2'b00, 16'h00F0, 16'h0F00); wait_result("and_zero", 1'b0); release_result("and_zero");
    accept(2'b01, 16'h8001, 16'h0000); wait_result("or_neg", 1'b0); release_result("or_neg");
    accept(2'b11, 16'h0000, 16'h0000); wait_result("nor_ones", 1'b0); release_result("nor_ones");

    // Back-pressure with an ignored in_valid pulse
    accept(2'b01, 16'h1200, 16'h0034); wait_result("bp", 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid = (i == 2);
      in_a = 16'hFFFF; in_b = 16'hFFFF; op = 2'b11;
      @(negedge clk);
      check("bp_hold", {10'd0, out_valid, in_ready, flags, out},
            {10'd0, 1'b1, 1'b0, last_e.fl, last_e.res});
    end
    in_valid = 1'b0;
    release_result("bp");
    @(negedge clk);
    @(negedge clk);
    check("bp_no_ghost", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});

    // Operand immunity after acceptance
    accept(2'b10, 16'hFFFF, 16'h0001); wait_result("stable", 1'b1); release_result("stable");

    // Asynchronous reset mid-RUN
    accept(2'b01, 16'h1111, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("partial_out", 32'(out), 32'h00000011);
    rst_n = 1'b0;
    #1;
    check("mid_reset", {10'd0, out_valid, in_ready, flags, out},
          {10'd0, 1'b0, 1'b1, 4'b0000, 16'h0000});
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept(2'b01, 16'h0F0F, 16'hF0F0); wait_result("post_reset", 1'b0);
    release_result("post_reset");

    // SLICE=WIDTH: latency 1, back-to-back every 3 cycles
    acc_k = -100; naccept = 0; nres = 0;
    iv16 = 1'b1; or16 = 1'b1; a16 = 16'h1357; b16 = 16'h00FF; op16 = 2'b00;
    for (int k = 0; k < 12; k++) begin
      if (ov16) begin
        check("s16_latency", 32'(k - acc_k), 32'd2);
        pop_exp("s16", e);
        check("s16_result", {12'd0, o16, f16}, {12'd0, e.res, e.fl});
        nres++;
      end
      if (ir16) begin
        if (naccept > 0) check("s16_interval", 32'(k - acc_k), 32'd3);
        acc_k = k;
        sb.push_back(model(op16, a16, b16, 16));
        naccept++;
      end else begin
        a16 = a16 + 16'h2B5D; b16 = ~b16; op16 = op16 + 2'd1;
      end
      @(negedge clk);
    end
    iv16 = 1'b0;
    check("s16_count", 32'(nres), 32'd4);

    // WIDTH=8, SLICE=1: latency 8
    a8 = 8'h80; b8 = 8'h00; op8 = 2'b10; iv8 = 1'b1;
    check("w8_ready", 32'(ir8), 32'd1);
    @(negedge clk);
    iv8 = 1'b0;
    cyc = 0;
    while (!ov8 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("w8_latency", 32'(cyc), 32'd8);
    e = model(2'b10, 16'h0080, 16'h0000, 8);
    check("w8_result", {20'd0, o8, f8}, {20'd0, e.res[7:0], e.fl});
    or8 = 1'b1;
    @(negedge clk);
    check("w8_release", {30'd0, ov8, ir8}, {30'd0, 1'b0, 1'b1});
    or8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/logic_unit_sliced.md
# logic_unit_sliced

Parametrised, multi-cycle bitwise logic unit for the ALU. It computes AND, OR, XOR or NOR of two WIDTH-bit operands, processing SLICE bits per clock so wide datapaths reuse narrow logic. It produces negative/zero/overflow/carry flags in the ALU's standard n_z_v_c order. It sits beside the other ALU function units behind a valid/ready handshake on both the operand side and the result side.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per cycle; 1 <= SLICE <= WIDTH. NSLICE = WIDTH/SLICE.
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result.
- flags_n_z_v_c  output  4  [3] negative, [2] zero, [1] overflow, [0] carry.

## Operation
- Three states:
  - IDLE: in_ready=1. On in_valid=1, latch in_a, in_b and op, clear the slice index, clear the ones-seen accumulator and `out`, then go to RUN.
  - RUN: each cycle, apply the latched op to bits [idx*SLICE +: SLICE] of the latched operands. Write that slice of `out`; ones-seen |= (|slice result); idx++. After the slice with idx = NSLICE-1, register the flags, assert out_valid and go to DONE.
  - DONE: out_valid=1; out and flags held stable. When out_ready=1, deassert out_valid and go to IDLE.
- Flags:
  - N = out[WIDTH-1].
  - Z = ~ones-seen, i.e. 1 only when all WIDTH result bits are 0.
  - V = 0 and C = 0 always.
- Latched operands and op are immune to input changes after acceptance.
- in_valid is ignored in RUN and DONE; there is no overlap between operations.
- `out` is only meaningful while out_valid=1. Partial slices are visible during RUN and must not be consumed.
- The slice index counts 0..NSLICE-1 and never wraps inside one operation. It is cleared on acceptance.
- With NSLICE=1, RUN lasts one cycle.

## Timing
- Reset values (asserted asynchronously, independent of clk):
  - state = IDLE, in_ready = 1.
  - out_valid = 0, out = 0, flags_n_z_v_c = 4'b0000.
  - slice index = 0, accumulator = 0.
- Reset mid-operation abandons the operation. No result is produced; the outputs take their reset values.
- Acceptance happens at the edge where in_valid && in_ready. Call it edge E0.
- Slices are computed at edges E1..E_NSLICE. out_valid is high after edge E_NSLICE, so latency is NSLICE cycles from acceptance.
- The result handshake completes at the first edge with out_valid && out_ready. in_ready is high from the next cycle.
- If out_ready is already high when out_valid rises, the result is held exactly one cycle.
- Minimum issue interval is NSLICE+2 cycles per operation.
- in_ready and out_valid are purely state-decoded, with no combinational path from in_valid or out_ready.
- Back-pressure: DONE may persist indefinitely. out, flags and out_valid remain constant for its whole duration.

## Test plan
All scenarios use WIDTH=16, SLICE=4 unless stated.
1. XOR: a=16'hA5A5, b=16'h0FF0, op=10 -> out=16'hAA55, flags=4'b1000, out_valid exactly 4 cycles after acceptance, in_ready=0 throughout.
2. Zero and negative flags:
   - XOR 16'h1234 with 16'h1234 -> out=16'h0000, flags=4'b0100.
   - AND 16'h00F0 with 16'h0F00 -> out=0, flags=4'b0100.
   - OR 16'h8001 with 16'h0000 -> out=16'h8001, flags=4'b1000.
   - NOR 16'h0000 with 16'h0000 -> out=16'hFFFF, flags=4'b1000.
3. Back-pressure: hold out_ready=0 for 6 cycles after out_valid -> out, flags and out_valid stable; in_ready=0; an in_valid pulse during this time is ignored. Raise out_ready -> out_valid drops after 1 edge, in_ready=1 the next cycle.
4. Operand stability: after acceptance, toggle in_a, in_b and op every cycle -> the result matches the latched values (XOR 16'hFFFF with 16'h0001 -> 16'hFFFE, flags 4'b1000).
5. Reset mid-RUN: assert rst_n=0 after 2 slices, asynchronously between edges -> out_valid=0, out=0 and flags=0 immediately, in_ready=1. Release reset; the next operation, OR 16'h0F0F with 16'hF0F0, gives 16'hFFFF, flags 4'b1000.
6. Parameter corners:
   - SLICE=16 -> latency 1, back-to-back issue every 3 cycles.
   - WIDTH=8, SLICE=1 -> latency 8; XOR 8'h80 with 8'h00 -> 8'h80, flags 4'b1000.
